// File: rtl/four_bank_mem_if.sv
// Request/response bus between the cache controller and the interleaved
// main memory. The controller drives the request side (master); the memory
// answers with read data, stall, per-bank occupancy and error (slave).
interface four_bank_mem_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic              wr;
   logic              rd;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              stall;
   logic [3:0]        busy;
   logic              err;

   modport master (
      output addr, data_in, wr, rd,
      input  data_out, data_valid, stall, busy, err
   );

   modport slave (
      input  addr, data_in, wr, rd,
      output data_out, data_valid, stall, busy, err
   );
endinterface

// File: rtl/four_bank_mem.sv
// Four-way interleaved main memory. Address bits [2:1] pick the bank and
// [ADDR_W-1:3] the row. Each bank stays occupied for BANK_BUSY cycles after
// an accept; reads return after a fixed RD_LAT cycles through a shift
// register, so responses never collide and always come back in order.
module four_bank_mem #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int BANK_BUSY = 4,
   parameter int RD_LAT    = 2
) (
   input logic           clk,
   input logic           rst,
   four_bank_mem_if.slave bus
);

   localparam int ROW_W = ADDR_W - 3;
   localparam int ROWS  = 1 << ROW_W;
   localparam int CNT_W = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;

   // Storage is deliberately left without reset.
   logic [DATA_W-1:0] mem_q [4][ROWS];

   logic [3:0][CNT_W-1:0]         cnt_q, cnt_d;
   logic [RD_LAT-1:0]             vld_q, vld_d;
   logic [RD_LAT-1:0][DATA_W-1:0] dat_q, dat_d;

   logic             req;
   logic             illegal;
   logic [1:0]       bank;
   logic [ROW_W-1:0] row;
   logic [3:0]       busy_vec;
   logic             bank_busy;
   logic             accept;
   logic             rd_accept;
   logic             wr_accept;
   logic [DATA_W-1:0] rd_word;

   // Decode the request, classify it, and derive the next counter and
   // read-pipeline state; reset suppresses every acceptance.
   always_comb begin
      req       = bus.rd | bus.wr;
      illegal   = req & ((bus.rd & bus.wr) | bus.addr[0]);
      bank      = bus.addr[2:1];
      row       = bus.addr[ADDR_W-1:3];
      for (int b = 0; b < 4; b++) begin
         busy_vec[b] = (cnt_q[b] != '0);
      end
      bank_busy = busy_vec[bank];
      accept    = ~rst & req & ~illegal & ~bank_busy;
      rd_accept = accept & bus.rd;
      wr_accept = accept & bus.wr;
      rd_word   = mem_q[bank][row];

      cnt_d = cnt_q;
      for (int b = 0; b < 4; b++) begin
         if (cnt_q[b] != '0) begin
            cnt_d[b] = cnt_q[b] - CNT_W'(1);
         end
         if (accept && (bank == 2'(b))) begin
            cnt_d[b] = CNT_W'(BANK_BUSY - 1);
         end
      end

      vld_d    = '0;
      dat_d    = '0;
      vld_d[0] = rd_accept;
      dat_d[0] = rd_accept ? rd_word : '0;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
   end

   // Bank occupancy counters and the read-return shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   // Memory array write port; a write is visible to the very next accept.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[bank][row] <= bus.data_in;
      end
   end

   assign bus.busy       = busy_vec;
   assign bus.stall      = ~rst & req & ~illegal & bank_busy;
   assign bus.err        = ~rst & illegal;
   assign bus.data_valid = vld_q[RD_LAT-1];
   assign bus.data_out   = dat_q[RD_LAT-1];

endmodule
